// File: rtl/sd_cmd_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : sd_cmd_tx                                              |
// | Description : Serialises one 48-bit SD command frame (start, tx bit, |
// |               index, argument, CRC7, end bit) onto the CMD line and  |
// |               sequences an external sd_crc_7 instance.               |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module sd_cmd_tx #(
    parameter int BIT_CNT_W = 6
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       TICK,
    input  logic       START,
    input  logic [5:0] INDEX,
    input  logic [31:0] ARG,
    output logic       BUSY,
    output logic       DONE,
    output logic       CMD_OUT,
    output logic       CMD_OE,
    output logic       CRC_RST,
    output logic       CRC_EN,
    output logic       CRC_BIT,
    input  logic [6:0] CRC_IN
);

    // Last index of the 40 CRC-covered bits, last index of the 7 CRC bits.
    localparam logic [BIT_CNT_W-1:0] c_LAST_DATA = BIT_CNT_W'(39);
    localparam logic [BIT_CNT_W-1:0] c_LAST_CRC  = BIT_CNT_W'(6);
    localparam logic [BIT_CNT_W-1:0] c_ONE       = BIT_CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_SEND = 3'd2,
        S_CRCS = 3'd3,
        S_ENDB = 3'd4
    } state_t;

    state_t                 r_state,   w_state_nxt;
    logic [39:0]            r_shift,   w_shift_nxt;
    logic [BIT_CNT_W-1:0]   r_cnt,     w_cnt_nxt;
    logic [5:0]             r_crc_sh,  w_crc_sh_nxt;
    logic                   r_busy,    w_busy_nxt;
    logic                   r_done,    w_done_nxt;
    logic                   r_cmd_out, w_cmd_out_nxt;
    logic                   r_cmd_oe,  w_cmd_oe_nxt;
    logic                   r_crc_rst, w_crc_rst_nxt;
    logic                   w_crc_en;
    logic                   w_crc_bit;

    // State and datapath registers; reset releases the line at once.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            r_crc_sh  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cmd_out <= 1'b1;
            r_cmd_oe  <= 1'b0;
            r_crc_rst <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_cnt     <= w_cnt_nxt;
            r_crc_sh  <= w_crc_sh_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_cmd_out <= w_cmd_out_nxt;
            r_cmd_oe  <= w_cmd_oe_nxt;
            r_crc_rst <= w_crc_rst_nxt;
        end
    end

    // Next-state, datapath update and CRC engine strobes; TICK=0 holds everything.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_cnt_nxt     = r_cnt;
        w_crc_sh_nxt  = r_crc_sh;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;
        w_cmd_out_nxt = r_cmd_out;
        w_cmd_oe_nxt  = r_cmd_oe;
        w_crc_rst_nxt = r_crc_rst;
        w_crc_en      = 1'b0;
        w_crc_bit     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (START) begin
                    w_shift_nxt   = {1'b0, 1'b1, INDEX, ARG};
                    w_busy_nxt    = 1'b1;
                    w_crc_rst_nxt = 1'b0;
                    w_state_nxt   = S_LOAD;
                end
            end
            S_LOAD: begin
                // The CRC consumes bit 0 on the same edge it appears on the line.
                w_crc_en  = TICK;
                w_crc_bit = r_shift[39];
                if (TICK) begin
                    w_cmd_out_nxt = r_shift[39];
                    w_cmd_oe_nxt  = 1'b1;
                    w_shift_nxt   = {r_shift[38:0], 1'b0};
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_SEND;
                end
            end
            S_SEND: begin
                // Feed the upcoming bit; after bit 39 is fed CRC_IN is final.
                w_crc_en  = TICK && (r_cnt < c_LAST_DATA);
                w_crc_bit = r_shift[39];
                if (TICK) begin
                    if (r_cnt == c_LAST_DATA) begin
                        w_cmd_out_nxt = CRC_IN[6];
                        w_crc_sh_nxt  = CRC_IN[5:0];
                        w_cnt_nxt     = '0;
                        w_state_nxt   = S_CRCS;
                    end else begin
                        w_cmd_out_nxt = r_shift[39];
                        w_shift_nxt   = {r_shift[38:0], 1'b0};
                        w_cnt_nxt     = r_cnt + c_ONE;
                    end
                end
            end
            S_CRCS: begin
                if (TICK) begin
                    if (r_cnt == c_LAST_CRC) begin
                        w_cmd_out_nxt = 1'b1;
                        w_state_nxt   = S_ENDB;
                    end else begin
                        w_cmd_out_nxt = r_crc_sh[5];
                        w_crc_sh_nxt  = {r_crc_sh[4:0], 1'b0};
                        w_cnt_nxt     = r_cnt + c_ONE;
                    end
                end
            end
            S_ENDB: begin
                if (TICK) begin
                    w_cmd_oe_nxt  = 1'b0;
                    w_cmd_out_nxt = 1'b1;
                    w_busy_nxt    = 1'b0;
                    w_crc_rst_nxt = 1'b1;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign CMD_OUT = r_cmd_out;
    assign CMD_OE  = r_cmd_oe;
    assign CRC_RST = r_crc_rst;
    assign CRC_EN  = w_crc_en;
    assign CRC_BIT = w_crc_bit;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_sd_cmd_tx                                           |
// | Description : Self-checking bench for sd_cmd_tx with a CRC7 engine   |
// |               model and a line monitor that rebuilds the bitstream.  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_sd_cmd_tx;

    logic        CLK;
    logic        RST_N;
    logic        TICK;
    logic        START;
    logic [5:0]  INDEX;
    logic [31:0] ARG;
    logic        BUSY;
    logic        DONE;
    logic        CMD_OUT;
    logic        CMD_OE;
    logic        CRC_RST;
    logic        CRC_EN;
    logic        CRC_BIT;
    logic [6:0]  CRC_IN;

    int checks   = 0;
    int failures = 0;
    int tick_period = 1;

    sd_cmd_tx #(.BIT_CNT_W(6)) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .TICK    (TICK),
        .START   (START),
        .INDEX   (INDEX),
        .ARG     (ARG),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .CMD_OUT (CMD_OUT),
        .CMD_OE  (CMD_OE),
        .CRC_RST (CRC_RST),
        .CRC_EN  (CRC_EN),
        .CRC_BIT (CRC_BIT),
        .CRC_IN  (CRC_IN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // SD CRC7 engine (x^7 + x^3 + 1), asynchronous active-high clear.
    logic [6:0] crc_q;
    always @(posedge CLK or posedge CRC_RST) begin
        if (CRC_RST) crc_q <= 7'h00;
        else if (CRC_EN) crc_q <= {crc_q[5:0], 1'b0} ^ ((CRC_BIT ^ crc_q[6]) ? 7'h09 : 7'h00);
    end
    assign CRC_IN = crc_q;

    // TICK generator: one cycle high out of every tick_period cycles.
    initial begin
        int phase;
        phase = 0;
        TICK  = 1'b1;
        forever begin
            @(negedge CLK);
            phase = (phase + 1 >= tick_period) ? 0 : phase + 1;
            TICK  = (phase == 0);
        end
    end

    // Line monitor: values sampled just before each rising edge.
    logic        mon_clr = 1'b0;
    logic [47:0] mon_stream;
    logic [6:0]  mon_crc;
    int mon_bits, mon_oe_cyc, mon_en, mon_en_notick, mon_rst_viol, mon_done;
    always @(posedge CLK) begin
        if (mon_clr) begin
            mon_stream    <= '0;
            mon_crc       <= '0;
            mon_bits      <= 0;
            mon_oe_cyc    <= 0;
            mon_en        <= 0;
            mon_en_notick <= 0;
            mon_rst_viol  <= 0;
            mon_done      <= 0;
        end else begin
            if (CMD_OE) mon_oe_cyc <= mon_oe_cyc + 1;
            if (CMD_OE && TICK) begin
                mon_stream <= {mon_stream[46:0], CMD_OUT};
                mon_bits   <= mon_bits + 1;
                if (mon_bits == 39) mon_crc <= CRC_IN;
            end
            if (CRC_EN) mon_en <= mon_en + 1;
            if (CRC_EN && !TICK) mon_en_notick <= mon_en_notick + 1;
            if (CRC_EN && CRC_RST) mon_rst_viol <= mon_rst_viol + 1;
            if (DONE) mon_done <= mon_done + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge CLK);
        mon_clr = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (DONE !== 1'b1 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_done_timeout"}, 64'(n < 3000), 64'd1);
    endtask

    // Issue one START pulse, then scramble INDEX/ARG to prove they were captured.
    task automatic send(input logic [5:0] idx, input logic [31:0] arg);
        INDEX = idx;
        ARG   = arg;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        INDEX = ~idx;
        ARG   = ~arg;
    endtask

    typedef struct {
        string       name;
        logic [5:0]  idx;
        logic [31:0] arg;
        int          period;
        logic [47:0] exp_stream;
        logic [6:0]  exp_crc;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{"cmd0",    6'd0,  32'h0000_0000, 1, 48'h4000_0000_0095, 7'h4A};
        vecs[1] = '{"cmd8",    6'd8,  32'h0000_01AA, 1, 48'h4800_0001_AA87, 7'h43};
        vecs[2] = '{"cmd17",   6'd17, 32'h0000_0000, 1, 48'h5100_0000_0055, 7'h2A};
        vecs[3] = '{"cmd0_t3", 6'd0,  32'h0000_0000, 3, 48'h4000_0000_0095, 7'h4A};

        RST_N = 1'b0;
        START = 1'b0;
        INDEX = '0;
        ARG   = '0;
        repeat (2) @(negedge CLK);
        check("rst_busy",    64'(BUSY),    64'd0);
        check("rst_done",    64'(DONE),    64'd0);
        check("rst_cmd_out", 64'(CMD_OUT), 64'd1);
        check("rst_cmd_oe",  64'(CMD_OE),  64'd0);
        check("rst_crc_rst", 64'(CRC_RST), 64'd1);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);

        // Table-driven frames.
        for (int i = 0; i < 4; i++) begin
            tick_period = vecs[i].period;
            repeat (4) @(negedge CLK);
            clear_mon();
            send(vecs[i].idx, vecs[i].arg);
            wait_done(vecs[i].name);
            repeat (3) @(negedge CLK);
            check({vecs[i].name, "_stream"}, 64'(mon_stream), 64'(vecs[i].exp_stream));
            check({vecs[i].name, "_bits"},   64'(mon_bits),   64'd48);
            check({vecs[i].name, "_oe_cyc"}, 64'(mon_oe_cyc), 64'(48 * vecs[i].period));
            check({vecs[i].name, "_crc"},    64'(mon_crc),    64'(vecs[i].exp_crc));
            check({vecs[i].name, "_crc_en"}, 64'(mon_en),     64'd40);
            check({vecs[i].name, "_en_notick"}, 64'(mon_en_notick), 64'd0);
            check({vecs[i].name, "_rst_order"}, 64'(mon_rst_viol),  64'd0);
            check({vecs[i].name, "_done_cnt"},  64'(mon_done),      64'd1);
            check({vecs[i].name, "_busy_end"},  64'(BUSY),          64'd0);
        end
        tick_period = 1;
        repeat (4) @(negedge CLK);

        // START while busy with a different index is ignored.
        clear_mon();
        send(6'd8, 32'h0000_01AA);
        repeat (10) @(negedge CLK);
        INDEX = 6'd17;
        ARG   = 32'hDEAD_BEEF;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        wait_done("busy_start");
        repeat (10) @(negedge CLK);
        check("busy_start_stream", 64'(mon_stream), 64'h4800_0001_AA87);
        check("busy_start_bits",   64'(mon_bits),   64'd48);
        check("busy_start_done",   64'(mon_done),   64'd1);
        check("busy_start_idle",   64'(BUSY),       64'd0);

        // START held through DONE: the next frame is accepted in the DONE cycle.
        clear_mon();
        INDEX = 6'd0;
        ARG   = 32'h0;
        START = 1'b1;
        wait_done("held_first");
        check("held_done_busy", 64'(BUSY), 64'd0);
        check("held_first_stream", 64'(mon_stream), 64'h4000_0000_0095);
        clear_mon();
        check("held_second_busy", 64'(BUSY), 64'd1);
        check("held_second_done", 64'(DONE), 64'd0);
        START = 1'b0;
        wait_done("held_second");
        repeat (3) @(negedge CLK);
        check("held_second_stream", 64'(mon_stream), 64'h4000_0000_0095);
        check("held_second_bits",   64'(mon_bits),   64'd48);
        check("held_second_crc_en", 64'(mon_en),     64'd40);
        check("held_second_done_cnt", 64'(mon_done), 64'd1);

        // Reset at bit 20 releases the line asynchronously, no DONE.
        repeat (4) @(negedge CLK);
        clear_mon();
        send(6'd17, 32'h0);
        begin
            int n;
            n = 0;
            while (mon_bits < 20 && n < 200) begin
                @(negedge CLK);
                n++;
            end
            check("mid_rst_reach_bit20", 64'(n < 200), 64'd1);
        end
        RST_N = 1'b0;
        #1;
        check("mid_rst_cmd_oe",  64'(CMD_OE),  64'd0);
        check("mid_rst_cmd_out", 64'(CMD_OUT), 64'd1);
        check("mid_rst_busy",    64'(BUSY),    64'd0);
        check("mid_rst_crc_rst", 64'(CRC_RST), 64'd1);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);
        check("mid_rst_no_done", 64'(mon_done), 64'd0);
        check("mid_rst_idle",    64'(BUSY),     64'd0);
        clear_mon();
        send(6'd17, 32'h0);
        wait_done("post_rst");
        repeat (3) @(negedge CLK);
        check("post_rst_stream", 64'(mon_stream), 64'h5100_0000_0055);
        check("post_rst_crc",    64'(mon_crc),    64'h2A);
        check("post_rst_crc_en", 64'(mon_en),     64'd40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sd_cmd_tx.md
Name: sd_cmd_tx

Overview:
- Serialises one 48-bit SD command frame onto the CMD line. Frame order: start bit 0, transmission bit 1, 6-bit index, 32-bit argument, 7-bit CRC, end bit 1.
- Sequences an external sd_crc_7 instance: holds it cleared while idle, feeds it the first 40 frame bits, then shifts the resulting CRC out on the line.
- Sits between the command-issue logic (register interface / DMA controller) and the CMD pad tristate.

Parameters:
- BIT_CNT_W, 6, width of the internal bit counter; must be ≥ 6.

Ports:
- CLK  in  1  system clock; all registers on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- TICK  in  1  bit-rate enable; the frame advances one bit per cycle with TICK=1.
- START  in  1  request to send; sampled only in IDLE.
- INDEX  in  6  command index, captured when START is accepted.
- ARG  in  32  command argument, captured when START is accepted.
- BUSY  out  1  registered; high from START acceptance until the frame ends.
- DONE  out  1  registered one-cycle pulse after the end bit.
- CMD_OUT  out  1  registered serial data to the CMD pad.
- CMD_OE  out  1  registered pad output enable.
- CRC_RST  out  1  registered; drives sd_crc_7 RST (active-high).
- CRC_EN  out  1  combinational; drives sd_crc_7 Enable.
- CRC_BIT  out  1  combinational; drives sd_crc_7 BITVAL.
- CRC_IN  in  7  sd_crc_7 CRC output.

Behaviour:
- Reset (RST_N=0, asynchronous) forces: state=IDLE, BUSY=0, DONE=0, CMD_OUT=1, CMD_OE=0, CRC_RST=1, shift and counter registers 0.
- States: IDLE, LOAD, SEND, CRCS, ENDB.
- IDLE:
  - CRC_RST=1, CRC_EN=0.
  - START=1 (TICK ignored): shifter <= {0,1,INDEX,ARG} (40 bits, MSB first); BUSY<=1; CRC_RST<=0; go to LOAD.
- LOAD: waits for TICK.
  - CRC_EN=TICK, CRC_BIT=shifter[39].
  - On TICK: CMD_OUT<=shifter[39]; CMD_OE<=1; shift left; count<=0; go to SEND.
  - CRC_RST is therefore deasserted at least one edge before the first CRC enable.
- SEND: CMD_OUT shows frame bit k (k = count, 0..39).
  - CRC_EN = TICK & (k ≤ 38); CRC_BIT = shifter[39] (next bit), so the CRC and CMD_OUT update on the same edge.
  - On TICK with k<39: CMD_OUT<=shifter[39]; shift; count+1.
  - On TICK with k=39 (CRC_IN is final): CMD_OUT<=CRC_IN[6]; crc_sh<=CRC_IN[5:0]; count<=0; go to CRCS.
- CRCS: shows CRC bits 6..0, one per TICK, MSB first; CRC_EN=0.
  - After the bit-0 period: CMD_OUT<=1 (end bit); go to ENDB.
- ENDB: on TICK: CMD_OE<=0; CMD_OUT<=1; BUSY<=0; CRC_RST<=1; DONE<=1 for one cycle; go to IDLE.
- Line activity:
  - CMD_OE is high for exactly 48 TICK-qualified bit periods.
  - TICK=0 anywhere freezes state, outputs and counters; CRC_EN=0.
- Boundary conditions:
  - START while BUSY is ignored.
  - START in the DONE cycle (IDLE) is accepted: back-to-back frames are separated by one LOAD period.
  - INDEX/ARG changes after acceptance have no effect.
  - Reset mid-frame releases the line immediately (CMD_OE=0) and returns to IDLE with no DONE.

Test Plan:
- CMD0, ARG=0x00000000, TICK=1 → CMD bitstream 0x400000000095, CMD_OE high exactly 48 cycles, DONE one pulse, CRC_IN sampled = 0x4A.
- CMD8, ARG=0x000001AA → stream 0x48000001AA87 (CRC 0x43); CMD17, ARG=0 → 0x510000000055 (CRC 0x2A).
- TICK asserted 1 cycle in 3 during CMD0 → identical bitstream, each bit held 3 cycles, no CRC_EN while TICK=0, CRC still 0x4A.
- START pulsed mid-frame with different INDEX → ignored, first frame unchanged; START held through DONE → second frame starts in the DONE cycle.
- RST_N low at bit 20 → CMD_OE=0, CMD_OUT=1, BUSY=0, CRC_RST=1 asynchronously; the next START sends a correct full frame.
- Check CRC_RST falls at least one edge before the first CRC_EN=1, and CRC_EN is asserted on exactly 40 edges per frame.
